// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU microcode sequencer: operand modes, ALU select codes
// and sequencer states, plus the mode-to-first-M-cycle mapping.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ModeReg = 2'd0,
        ModeImm = 2'd1,
        ModeMem = 2'd2,
        ModeRmw = 2'd3
    } seq_mode_e;

    localparam int unsigned SEL_NONE = 0;
    localparam int unsigned SEL_A    = 1;
    localparam int unsigned SEL_Z    = 2;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StExec  = 3'd2,
        StWrite = 3'd3,
        StFetch = 3'd4
    } seq_state_e;

    // REG runs straight to EXEC; every other mode needs an operand read first.
    function automatic seq_state_e first_state(input seq_mode_e mode);
        return (mode == ModeReg) ? StExec : StRead;
    endfunction

endpackage

// File: rtl/mcycle_step_counter.sv
// One-hot T-step counter with stall: advances on i_En, wraps from the last step to step 0.
module mcycle_step_counter #(
    parameter int unsigned STEPS = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_En,
    output logic [STEPS-1:0] o_Step,
    output logic             o_Last
);

    logic [STEPS-1:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        if (i_En) begin
            step_d = {step_q[STEPS-2:0], step_q[STEPS-1]};
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            step_q <= STEPS'(1);
        end else begin
            step_q <= step_d;
        end
    end

    assign o_Step = step_q;
    assign o_Last = step_q[STEPS-1];

endmodule

// File: rtl/alu_microcode_sequencer.sv
// Multi-M-cycle ALU microcode sequencer: walks REG/IMM/MEM/RMW operand modes through
// READ/EXEC/WRITE/FETCH M-cycles and decodes ALU selects, memory strobes and IR fetch.
module alu_microcode_sequencer #(
    parameter int unsigned STEPS_PER_MCYCLE = 4,
    parameter int unsigned ALU_STEP         = 2,
    parameter int unsigned ALU_CTRL_W       = 7,
    parameter int unsigned SEL_W            = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_n,
    input  logic                        i_Start,
    input  logic [1:0]                  i_Mode,
    input  logic [ALU_CTRL_W-1:0]       i_ALU_Op,
    input  logic                        i_Dst_A,
    input  logic                        i_Wait,
    output logic                        o_Busy,
    output logic                        o_Done,
    output logic [STEPS_PER_MCYCLE-1:0] o_Cycle_Step,
    output logic                        o_IR_Fetch,
    output logic                        o_Mem_Read,
    output logic                        o_Mem_Write,
    output logic                        o_Addr_Sel,
    output logic [SEL_W-1:0]            o_ReadALU8,
    output logic [SEL_W-1:0]            o_WriteALU8,
    output logic [ALU_CTRL_W-1:0]       o_ALU_Control,
    output logic                        o_Flags_WE
);

    import alu_seq_pkg::*;

    if (STEPS_PER_MCYCLE < 3 || STEPS_PER_MCYCLE > 8) begin : g_bad_steps
        $error("STEPS_PER_MCYCLE must be within 3..8");
    end
    if (ALU_STEP >= STEPS_PER_MCYCLE - 1) begin : g_bad_alu_step
        $error("ALU_STEP must be below STEPS_PER_MCYCLE-1");
    end
    if (SEL_W < 2) begin : g_bad_sel_w
        $error("SEL_W must be at least 2");
    end

    seq_state_e              state_q, state_d;
    seq_mode_e               mode_q, mode_d;
    logic [ALU_CTRL_W-1:0]   op_q, op_d;
    logic                    dst_a_q, dst_a_d;

    logic [STEPS_PER_MCYCLE-1:0] step;
    logic                        last_step;
    logic                        busy;
    logic                        final_mcycle;
    logic                        done;
    logic                        accept;
    logic                        alu_step;
    seq_mode_e                   mode_in;

    assign mode_in      = seq_mode_e'(i_Mode);
    assign busy         = (state_q != StIdle);
    // EXEC is always the last M-cycle outside RMW; RMW finishes in FETCH.
    assign final_mcycle = (state_q == StExec) || (state_q == StFetch);
    assign done         = final_mcycle && last_step && !i_Wait;
    assign accept       = i_Start && !i_Wait && ((state_q == StIdle) || done);
    assign alu_step     = ((state_q == StExec) || (state_q == StWrite)) && step[ALU_STEP];

    mcycle_step_counter #(
        .STEPS(STEPS_PER_MCYCLE)
    ) u_step_counter (
        .i_Clk  (i_Clk),
        .i_Rst_n(i_Rst_n),
        .i_En   (busy && !i_Wait),
        .o_Step (step),
        .o_Last (last_step)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        op_d    = op_q;
        dst_a_d = dst_a_q;
        if (accept) begin
            state_d = first_state(mode_in);
            mode_d  = mode_in;
            op_d    = i_ALU_Op;
            dst_a_d = i_Dst_A && (mode_in != ModeRmw);
        end else if (busy && last_step && !i_Wait) begin
            unique case (state_q)
                StRead:  state_d = (mode_q == ModeRmw) ? StWrite : StExec;
                StWrite: state_d = StFetch;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= StIdle;
            mode_q  <= ModeReg;
            op_q    <= '0;
            dst_a_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            op_q    <= op_d;
            dst_a_q <= dst_a_d;
        end
    end

    always_comb begin
        o_Busy        = busy;
        o_Done        = done;
        o_Cycle_Step  = busy ? step : '0;
        o_IR_Fetch    = final_mcycle;
        o_Mem_Read    = (state_q == StRead);
        o_Addr_Sel    = ((state_q == StRead) && (mode_q != ModeImm)) || (state_q == StWrite);
        o_Mem_Write   = (state_q == StWrite) && step[ALU_STEP+1];
        o_ReadALU8    = SEL_W'(SEL_NONE);
        o_WriteALU8   = SEL_W'(SEL_NONE);
        o_ALU_Control = '0;
        o_Flags_WE    = 1'b0;
        if (alu_step) begin
            o_ReadALU8    = (mode_q == ModeReg) ? SEL_W'(SEL_A) : SEL_W'(SEL_Z);
            o_WriteALU8   = dst_a_q ? SEL_W'(SEL_A) : SEL_W'(SEL_Z);
            o_ALU_Control = op_q;
            o_Flags_WE    = 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_microcode_sequencer.sv
// Randomised and directed bench for alu_microcode_sequencer against a per-M-cycle list model.
module tb_alu_microcode_sequencer;

    localparam int STEPS  = 4;
    localparam int ALU_ST = 2;
    localparam int CTRL_W = 7;
    localparam int SEL_W  = 2;

    localparam int K_NONE  = 0;
    localparam int K_RD_PC = 1;
    localparam int K_RD_HL = 2;
    localparam int K_EXEC  = 3;
    localparam int K_WRITE = 4;
    localparam int K_FETCH = 5;

    logic              clk = 1'b0;
    logic              i_Rst_n = 1'b0;
    logic              i_Start = 1'b0;
    logic [1:0]        i_Mode = 2'd0;
    logic [CTRL_W-1:0] i_ALU_Op = '0;
    logic              i_Dst_A = 1'b0;
    logic              i_Wait = 1'b0;
    logic              o_Busy, o_Done, o_IR_Fetch, o_Mem_Read, o_Mem_Write, o_Addr_Sel, o_Flags_WE;
    logic [STEPS-1:0]  o_Cycle_Step;
    logic [SEL_W-1:0]  o_ReadALU8, o_WriteALU8;
    logic [CTRL_W-1:0] o_ALU_Control;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the list of M-cycles the current op walks through.
    int          m_kinds[$];
    bit          m_busy = 0;
    int          m_idx  = 0;
    int          m_step = 0;
    int          m_mode = 0;
    logic [6:0]  m_op   = '0;
    bit          m_dst  = 0;

    always #5 clk = ~clk;

    alu_microcode_sequencer #(
        .STEPS_PER_MCYCLE(STEPS),
        .ALU_STEP        (ALU_ST),
        .ALU_CTRL_W      (CTRL_W),
        .SEL_W           (SEL_W)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_n      (i_Rst_n),
        .i_Start      (i_Start),
        .i_Mode       (i_Mode),
        .i_ALU_Op     (i_ALU_Op),
        .i_Dst_A      (i_Dst_A),
        .i_Wait       (i_Wait),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_Cycle_Step (o_Cycle_Step),
        .o_IR_Fetch   (o_IR_Fetch),
        .o_Mem_Read   (o_Mem_Read),
        .o_Mem_Write  (o_Mem_Write),
        .o_Addr_Sel   (o_Addr_Sel),
        .o_ReadALU8   (o_ReadALU8),
        .o_WriteALU8  (o_WriteALU8),
        .o_ALU_Control(o_ALU_Control),
        .o_Flags_WE   (o_Flags_WE)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kinds.delete();
        m_busy = 0;
        m_idx  = 0;
        m_step = 0;
    endtask

    task automatic model_load(input int mode, input logic [6:0] op, input bit dst);
        m_kinds.delete();
        case (mode)
            0: m_kinds.push_back(K_EXEC);
            1: begin m_kinds.push_back(K_RD_PC); m_kinds.push_back(K_EXEC); end
            2: begin m_kinds.push_back(K_RD_HL); m_kinds.push_back(K_EXEC); end
            default: begin
                m_kinds.push_back(K_RD_HL);
                m_kinds.push_back(K_WRITE);
                m_kinds.push_back(K_FETCH);
            end
        endcase
        m_mode = mode;
        m_op   = op;
        m_dst  = dst;
        m_busy = 1;
        m_idx  = 0;
        m_step = 0;
    endtask

    function automatic int cur_kind();
        return m_busy ? m_kinds[m_idx] : K_NONE;
    endfunction

    function automatic bit in_final();
        return m_busy && (m_idx == m_kinds.size() - 1);
    endfunction

    task automatic check_outputs();
        int kind;
        bit alu;
        int rd, wr;
        kind = cur_kind();
        alu  = (kind == K_EXEC || kind == K_WRITE) && (m_step == ALU_ST);
        rd   = !alu ? 0 : (m_mode == 0 ? 1 : 2);
        wr   = !alu ? 0 : ((m_mode == 3 || !m_dst) ? 2 : 1);
        check_eq("busy", o_Busy, m_busy);
        check_eq("cycle_step", o_Cycle_Step, m_busy ? (32'd1 << m_step) : 32'd0);
        check_eq("done", o_Done, in_final() && m_step == STEPS - 1 && !i_Wait);
        check_eq("ir_fetch", o_IR_Fetch, in_final());
        check_eq("mem_read", o_Mem_Read, kind == K_RD_PC || kind == K_RD_HL);
        check_eq("addr_sel", o_Addr_Sel, kind == K_RD_HL || kind == K_WRITE);
        check_eq("mem_write", o_Mem_Write, kind == K_WRITE && m_step == ALU_ST + 1);
        check_eq("read_sel", o_ReadALU8, rd);
        check_eq("write_sel", o_WriteALU8, wr);
        check_eq("alu_ctrl", o_ALU_Control, alu ? m_op : 7'd0);
        check_eq("flags_we", o_Flags_WE, alu);
    endtask

    task automatic model_step();
        bit was_busy, done;
        if (i_Wait) return;
        was_busy = m_busy;
        done     = in_final() && m_step == STEPS - 1;
        if (m_busy) begin
            m_step++;
            if (m_step == STEPS) begin
                m_step = 0;
                m_idx++;
                if (m_idx == m_kinds.size()) model_reset();
            end
        end
        if (i_Start && (!was_busy || done)) model_load(i_Mode, i_ALU_Op, i_Dst_A);
    endtask

    task automatic do_cycle(input bit start, input logic [1:0] mode, input logic [6:0] op,
                            input bit dst, input bit wt);
        @(negedge clk);
        i_Start  = start;
        i_Mode   = mode;
        i_ALU_Op = op;
        i_Dst_A  = dst;
        i_Wait   = wt;
        #1;
        check_outputs();
        model_step();
    endtask

    // Launch one op from idle and measure cycles until Done, with an optional wait burst.
    task automatic run_op(input string tag, input logic [1:0] mode, input logic [6:0] op,
                          input bit dst, input int wait_from, input int wait_len,
                          input int exp_lat);
        int lat;
        lat = 0;
        do_cycle(1'b1, mode, op, dst, 1'b0);
        for (int c = 1; c <= 100; c++) begin
            do_cycle(1'b0, mode, op, dst, (c >= wait_from) && (c < wait_from + wait_len));
            lat = c;
            if (o_Done) break;
        end
        check_eq(tag, lat, exp_lat);
        do_cycle(1'b0, mode, op, dst, 1'b0);
    endtask

    initial begin
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        i_Rst_n = 1'b1;
        do_cycle(1'b0, 2'd0, 7'h00, 1'b0, 1'b0);

        run_op("lat_reg", 2'd0, 7'h5A, 1'b1, 0, 0, 4);
        run_op("lat_mem", 2'd2, 7'h33, 1'b1, 0, 0, 8);
        run_op("lat_rmw", 2'd3, 7'h11, 1'b1, 0, 0, 12);
        run_op("lat_imm_wait", 2'd1, 7'h6C, 1'b0, 7, 3, 11);

        // Back-to-back REG ops on the Done cycle, plus an ignored mid-sequence start.
        do_cycle(1'b1, 2'd0, 7'h21, 1'b1, 1'b0);
        do_cycle(1'b0, 2'd0, 7'h00, 1'b0, 1'b0);
        do_cycle(1'b1, 2'd3, 7'h7F, 1'b0, 1'b0);
        do_cycle(1'b0, 2'd0, 7'h00, 1'b0, 1'b0);
        do_cycle(1'b1, 2'd0, 7'h42, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) do_cycle(1'b0, 2'd0, 7'h00, 1'b0, 1'b0);

        // Reset asserted at the ALU step of the RMW write-back cycle.
        do_cycle(1'b1, 2'd3, 7'h55, 1'b1, 1'b0);
        for (int c = 1; c <= 7; c++) do_cycle(1'b0, 2'd3, 7'h55, 1'b1, 1'b0);
        #1;
        i_Rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        #1;
        check_outputs();
        check_eq("rst_no_mem_write", o_Mem_Write, 1'b0);
        i_Rst_n = 1'b1;
        do_cycle(1'b0, 2'd0, 7'h00, 1'b0, 1'b0);
        check_eq("rst_idle_busy", o_Busy, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            do_cycle(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                     7'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
